// File: rtl/averager_acq_ctrl.sv
// Acquisition sequencer for the averager: configures average-by, arms on trigger,
// forwards avg_by*num_frames sample valids and counts averaged results.
// Optional DRAIN watchdog enabled by defining AVG_CTRL_DRAIN_TIMEOUT_EN.
module averager_acq_ctrl #(
    parameter int INT_MAX_AVERAGE_BY = 10,
    parameter int INT_MAX_FRAMES     = 1024,
    parameter int INT_FLUSH_CYCLES   = 2,
    parameter int INT_DRAIN_TIMEOUT  = 16,
    localparam int AVG_W = $clog2(INT_MAX_AVERAGE_BY),
    localparam int FRM_W = $clog2(INT_MAX_FRAMES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [AVG_W-1:0] i_avg_by_m1,
    input  logic [FRM_W-1:0] i_num_frames,
    input  logic             i_trigger,
    input  logic             i_valid,
    input  logic             i_valid_averaged,
    output logic             o_avg_cmd_valid,
    output logic [AVG_W-1:0] o_avg_cmd_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_armed,
    output logic             o_done,
    output logic             o_error,
    output logic [FRM_W-1:0] o_frames_done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CONFIG  = 3'd1;
    localparam logic [2:0] ST_FLUSH   = 3'd2;
    localparam logic [2:0] ST_ARM     = 3'd3;
    localparam logic [2:0] ST_ACQUIRE = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // One timer serves both the FLUSH wait and the DRAIN watchdog.
    localparam int TMR_MAX = (INT_FLUSH_CYCLES > INT_DRAIN_TIMEOUT) ? INT_FLUSH_CYCLES : INT_DRAIN_TIMEOUT;
    localparam int CNT_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(INT_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMR_ONE    = CNT_W'(1);
    localparam logic [AVG_W-1:0] AVG_MAX_M1 = AVG_W'(INT_MAX_AVERAGE_BY - 1);
    localparam logic [AVG_W-1:0] AVG_ONE    = AVG_W'(1);
    localparam logic [FRM_W-1:0] FRM_MAX    = FRM_W'(INT_MAX_FRAMES);
    localparam logic [FRM_W-1:0] FRM_ONE    = FRM_W'(1);
`ifdef AVG_CTRL_DRAIN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(INT_DRAIN_TIMEOUT - 1);
`endif

    logic [2:0]       state_reg,       state_next;
    logic [AVG_W-1:0] avg_m1_reg,      avg_m1_next;
    logic [FRM_W-1:0] num_frames_reg,  num_frames_next;
    logic [AVG_W-1:0] sample_cnt_reg,  sample_cnt_next;
    logic [FRM_W-1:0] frame_cnt_reg,   frame_cnt_next;
    logic [FRM_W-1:0] frames_done_reg, frames_done_next;
    logic [CNT_W-1:0] timer_reg,       timer_next;
    logic             acq_en_reg,      acq_en_next;
    logic             cmd_valid_reg,   cmd_valid_next;
    logic             error_reg,       error_next;

    logic fwd;
    logic last_sample;
    logic avg_pulse;
    logic frames_reached;

    // Abort gates the forwarded valid in the same cycle it is asserted.
    assign fwd            = i_valid & acq_en_reg & ~i_abort;
    assign last_sample    = (sample_cnt_reg == avg_m1_reg) && (frame_cnt_reg == num_frames_reg - FRM_ONE);
    assign avg_pulse      = i_valid_averaged && ((state_reg == ST_ACQUIRE) || (state_reg == ST_DRAIN))
                            && (frames_done_reg < num_frames_reg);
    assign frames_reached = (frames_done_reg == num_frames_reg)
                            || (avg_pulse && (frames_done_reg + FRM_ONE == num_frames_reg));

    always_comb begin
        state_next       = state_reg;
        avg_m1_next      = avg_m1_reg;
        num_frames_next  = num_frames_reg;
        sample_cnt_next  = sample_cnt_reg;
        frame_cnt_next   = frame_cnt_reg;
        frames_done_next = avg_pulse ? frames_done_reg + FRM_ONE : frames_done_reg;
        timer_next       = '0;
        acq_en_next      = acq_en_reg;
        cmd_valid_next   = 1'b0;
        error_next       = 1'b0;

        if (i_abort && (state_reg != ST_IDLE)) begin
            state_next  = ST_IDLE;
            acq_en_next = 1'b0;
            error_next  = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        if ((i_num_frames == '0) || (i_num_frames > FRM_MAX)) begin
                            error_next = 1'b1;
                        end else begin
                            avg_m1_next      = (i_avg_by_m1 > AVG_MAX_M1) ? AVG_MAX_M1 : i_avg_by_m1;
                            num_frames_next  = i_num_frames;
                            frames_done_next = '0;
                            sample_cnt_next  = '0;
                            frame_cnt_next   = '0;
                            cmd_valid_next   = 1'b1;
                            state_next       = ST_CONFIG;
                        end
                    end
                end
                ST_CONFIG: begin
                    state_next = ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (timer_reg == FLUSH_LAST) begin
                        state_next = ST_ARM;
                    end else begin
                        timer_next = timer_reg + TMR_ONE;
                    end
                end
                ST_ARM: begin
                    if (i_trigger) begin
                        acq_en_next = 1'b1;
                        state_next  = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (fwd) begin
                        if (last_sample) begin
                            acq_en_next = 1'b0;
                            state_next  = ST_DRAIN;
                        end else if (sample_cnt_reg == avg_m1_reg) begin
                            sample_cnt_next = '0;
                            frame_cnt_next  = frame_cnt_reg + FRM_ONE;
                        end else begin
                            sample_cnt_next = sample_cnt_reg + AVG_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (frames_reached) begin
                        state_next = ST_DONE;
`ifdef AVG_CTRL_DRAIN_TIMEOUT_EN
                    end else if (timer_reg == DRAIN_LAST) begin
                        state_next = ST_IDLE;
                        error_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + TMR_ONE;
`endif
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next  = ST_IDLE;
                    acq_en_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            avg_m1_reg      <= '0;
            num_frames_reg  <= '0;
            sample_cnt_reg  <= '0;
            frame_cnt_reg   <= '0;
            frames_done_reg <= '0;
            timer_reg       <= '0;
            acq_en_reg      <= 1'b0;
            cmd_valid_reg   <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            avg_m1_reg      <= avg_m1_next;
            num_frames_reg  <= num_frames_next;
            sample_cnt_reg  <= sample_cnt_next;
            frame_cnt_reg   <= frame_cnt_next;
            frames_done_reg <= frames_done_next;
            timer_reg       <= timer_next;
            acq_en_reg      <= acq_en_next;
            cmd_valid_reg   <= cmd_valid_next;
            error_reg       <= error_next;
        end
    end

    assign o_avg_cmd_valid = cmd_valid_reg;
    assign o_avg_cmd_data  = avg_m1_reg;
    assign o_valid         = fwd;
    assign o_busy          = (state_reg != ST_IDLE);
    assign o_armed         = (state_reg == ST_ARM);
    assign o_done          = (state_reg == ST_DONE);
    assign o_error         = error_reg;
    assign o_frames_done   = frames_done_reg;

endmodule
